// File: rtl/maze_pkg.sv
// Shared maze-solver definitions: location width, maze geometry and replay FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maze_pkg;
  localparam int LOC_W    = 8;
  localparam int MAZE_DIM = 16;
  localparam logic [LOC_W-1:0] DEST_LOC = 8'hFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    PLAY = ST_PLAY,
    DONE = ST_DONE
  } state_e;
endpackage

// File: rtl/loc_ram.sv
// Location storage: DEPTH x LOC_W register array, one write port, two async read ports.
// Latency: write lands at the clock edge, reads are combinational.
// Backpressure: none; the owner sequences all accesses.
module loc_ram #(
  parameter int DEPTH = 256,
  parameter int LOC_W = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [LOC_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  output logic [LOC_W-1:0] rdata_a_o,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [LOC_W-1:0] rdata_b_o
);
  logic [LOC_W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; only the stack pointer defines validity.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/path_stack_player.sv
// Maze path stack: push/pop while solving, then replays entries bottom-to-top as a stream.
// Latency: push visible on top next cycle; replay first beat valid one cycle after run.
// Backpressure: out_loc/out_valid held stable until out_ready; one beat per cycle otherwise.
module path_stack_player #(
  parameter int DEPTH = 256,
  parameter int LOC_W = maze_pkg::LOC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [LOC_W-1:0] din,
  output logic [LOC_W-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             err,
  input  logic             run,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOC_W-1:0] out_loc,
  output logic             run_done
);
  import maze_pkg::*;

  localparam int AW   = $clog2(DEPTH);
  localparam int SP_W = AW + 1;

  state_e           state_q, state_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [LOC_W-1:0] out_loc_q, out_loc_d;
  logic             run_done_q, run_done_d;
  logic             err_q, err_d;

  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    rd_addr;
  logic [LOC_W-1:0] top_dat;
  logic [LOC_W-1:0] rd_dat;
  logic             last_beat;

  assign empty     = (sp_q == '0);
  assign full      = (sp_q == SP_W'(DEPTH));
  assign top_addr  = AW'(sp_q - SP_W'(1));
  assign last_beat = (rd_ptr_q == top_addr);
  assign top       = empty ? '0 : top_dat;

  assign out_valid = out_valid_q;
  assign out_loc   = out_loc_q;
  assign run_done  = run_done_q;
  assign err       = err_q;

  loc_ram #(
    .DEPTH (DEPTH),
    .LOC_W (LOC_W),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (din),
    .raddr_a_i (top_addr),
    .rdata_a_o (top_dat),
    .raddr_b_i (rd_addr),
    .rdata_b_o (rd_dat)
  );

  // State and output registers; async reset returns everything except memory to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sp_q        <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_loc_q   <= '0;
      run_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_loc_q   <= out_loc_d;
      run_done_q  <= run_done_d;
      err_q       <= err_d;
    end
  end

  // Next state: clear wins, then the replay FSM, then solve-mode push/pop (IDLE only).
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_loc_d   = out_loc_q;
    run_done_d  = 1'b0;
    err_d       = err_q;
    ram_we      = 1'b0;
    ram_waddr   = sp_q[AW-1:0];
    // Replay port looks one entry ahead so the next beat is ready at the handshake.
    rd_addr     = (state_q == PLAY) ? rd_ptr_q + AW'(1) : '0;

    if (clr) begin
      sp_d        = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            // A run request takes the cycle; any push/pop alongside it is dropped.
            if (!empty) begin
              out_loc_d   = rd_dat;
              rd_ptr_d    = '0;
              out_valid_d = 1'b1;
              state_d     = PLAY;
            end else begin
              run_done_d  = 1'b1;
            end
          end else if (push && (!pop || empty)) begin
            if (full) begin
              err_d = 1'b1;
            end else begin
              ram_we = 1'b1;
              sp_d   = sp_q + SP_W'(1);
            end
          end else if (push && pop) begin
            ram_we    = 1'b1;
            ram_waddr = top_addr;
          end else if (pop) begin
            if (empty) err_d = 1'b1;
            else       sp_d  = sp_q - SP_W'(1);
          end
        end
        PLAY: begin
          if (push || pop) err_d = 1'b1;
          if (out_ready) begin
            if (last_beat) begin
              out_valid_d = 1'b0;
              run_done_d  = 1'b1;
              state_d     = DONE;
            end else begin
              rd_ptr_d  = rd_ptr_q + AW'(1);
              out_loc_d = rd_dat;
            end
          end
        end
        DONE: begin
          if (push || pop) err_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_path_stack_player.sv
module tb_path_stack_player;
  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst, clr, push, pop, run, out_ready;
  logic [7:0] din;
  logic [7:0] top, out_loc;
  logic       empty, full, err, out_valid, run_done;

  int tests = 0;
  int fails = 0;

  // Reference model: a plain queue as the stack plus a sticky error flag.
  logic [7:0] m_stk[$];
  bit         m_err;
  logic [7:0] got[$];

  path_stack_player #(.DEPTH(DEPTH), .LOC_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .din(din),
    .top(top), .empty(empty), .full(full), .err(err), .run(run),
    .out_valid(out_valid), .out_ready(out_ready), .out_loc(out_loc),
    .run_done(run_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_top();
    return (m_stk.size() == 0) ? 8'h00 : m_stk[m_stk.size()-1];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_stk.delete();
    m_err = 0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    m_stk.delete();
    m_err = 0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // One solve-mode cycle; the model applies the stack rules directly.
  task automatic do_op(input bit p, input bit q, input logic [7:0] d);
    push = p; pop = q; din = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    if (p && (!q || m_stk.size() == 0)) begin
      if (m_stk.size() == DEPTH) m_err = 1;
      else m_stk.push_back(d);
    end else if (p && q) begin
      m_stk[m_stk.size()-1] = d;
    end else if (q) begin
      if (m_stk.size() == 0) m_err = 1;
      else void'(m_stk.pop_back());
    end
  endtask

  // Issues run, then drives out_ready per mode and records accepted beats in got.
  // mode 0: always ready; 1: ready pattern 1,0,0,...; 2: random.
  task automatic replay_collect(input int mode, input int push_at, output int cycles,
                                output bit done_seen, output bit stable_ok,
                                output bit valid_seen);
    bit         prev_hold, r, v;
    logic [7:0] prev_loc, l;
    got.delete();
    cycles = 0; stable_ok = 1; prev_hold = 0; prev_loc = 8'h00;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    done_seen  = run_done;
    valid_seen = out_valid;
    for (int c = 0; c < 1200 && !done_seen; c++) begin
      if (out_valid) valid_seen = 1;
      if (prev_hold && out_loc !== prev_loc) stable_ok = 0;
      case (mode)
        0:       r = 1'b1;
        1:       r = (c % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      push = (c == push_at);
      din  = 8'hAA;
      v = out_valid; l = out_loc;
      @(posedge clk); #1;
      push = 1'b0;
      cycles++;
      if (v && r) got.push_back(l);
      prev_hold = v && !r;
      prev_loc  = l;
      if (run_done) done_seen = 1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    tests++;
    if ({top, empty, full, err, out_valid, out_loc, run_done} !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got top=%h empty=%b full=%b err=%b valid=%b loc=%h done=%b, expected 00 1 0 0 0 00 0",
               top, empty, full, err, out_valid, out_loc, run_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_stk.delete(); m_err = 0;
  endtask

  task automatic test_push_pop();
    do_reset();
    do_op(1, 0, 8'h00); do_op(1, 0, 8'h01); do_op(1, 0, 8'h11);
    tests++;
    if (top !== 8'h11 || empty !== 1'b0) begin
      fails++; $display("FAIL push3_top: got top=%h empty=%b, expected 11 0", top, empty);
    end
    do_op(0, 1, 8'h00);
    tests++;
    if (top !== 8'h01) begin fails++; $display("FAIL pop_top: got %h expected 01", top); end
    do_op(0, 1, 8'h00); do_op(0, 1, 8'h00);
    tests++;
    if (top !== 8'h00 || empty !== 1'b1 || err !== 1'b0) begin
      fails++; $display("FAIL pop_to_empty: got top=%h empty=%b err=%b, expected 00 1 0", top, empty, err);
    end
  endtask

  task automatic test_replace_err();
    do_reset();
    do_op(1, 0, 8'h10);
    do_op(1, 1, 8'h20);
    tests++;
    if (top !== 8'h20 || empty !== 1'b0) begin
      fails++; $display("FAIL replace_top: got top=%h empty=%b, expected 20 0", top, empty);
    end
    do_op(0, 1, 8'h00);
    tests++;
    if (empty !== 1'b1 || err !== 1'b0) begin
      fails++; $display("FAIL replace_keeps_sp: got empty=%b err=%b, expected 1 0", empty, err);
    end
    do_op(0, 1, 8'h00);
    idle_cycle(); do_op(1, 0, 8'h33); idle_cycle();
    tests++;
    if (err !== 1'b1 || top !== 8'h33) begin
      fails++; $display("FAIL underflow_sticky: got err=%b top=%h, expected 1 33", err, top);
    end
    do_clr();
    tests++;
    if (err !== 1'b0 || empty !== 1'b1) begin
      fails++; $display("FAIL clr_clears: got err=%b empty=%b, expected 0 1", err, empty);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) do_op(1, 0, 8'(i));
    tests++;
    if (full !== 1'b0 || top !== 8'hFE) begin
      fails++; $display("FAIL almost_full: got full=%b top=%h, expected 0 fe", full, top);
    end
    do_op(1, 0, 8'hFF);
    tests++;
    if (full !== 1'b1 || err !== 1'b0 || top !== 8'hFF) begin
      fails++; $display("FAIL full_flag: got full=%b err=%b top=%h, expected 1 0 ff", full, err, top);
    end
    do_op(1, 0, 8'h5A);
    tests++;
    if (full !== 1'b1 || err !== 1'b1 || top !== 8'hFF) begin
      fails++; $display("FAIL overflow: got full=%b err=%b top=%h, expected 1 1 ff", full, err, top);
    end
    do_op(0, 1, 8'h00);
    tests++;
    if (full !== 1'b0 || top !== 8'hFE) begin
      fails++; $display("FAIL pop_from_full: got full=%b top=%h, expected 0 fe", full, top);
    end
  endtask

  task automatic test_replay();
    int cyc; bit dn, st, vs; bit ok;
    logic [7:0] exp_path [5];
    exp_path = '{8'h00, 8'h01, 8'h11, 8'h12, 8'hFF};
    do_reset();
    foreach (exp_path[i]) do_op(1, 0, exp_path[i]);
    replay_collect(0, -1, cyc, dn, st, vs);
    ok = (got.size() == 5);
    for (int i = 0; i < 5 && ok; i++) if (got[i] !== exp_path[i]) ok = 0;
    tests++;
    if (!ok || cyc != 5 || !dn) begin
      fails++; $display("FAIL replay_full_rate: got beats=%0d cycles=%0d done=%b, expected 5 5 1", got.size(), cyc, dn);
    end
    idle_cycle();
    tests++;
    if (run_done !== 1'b0 || out_valid !== 1'b0 || top !== 8'hFF || err !== 1'b0) begin
      fails++; $display("FAIL replay_after: got done=%b valid=%b top=%h err=%b, expected 0 0 ff 0", run_done, out_valid, top, err);
    end
  endtask

  task automatic test_backpressure();
    int cyc; bit dn, st, vs; bit ok;
    logic [7:0] exp_path [5];
    exp_path = '{8'h00, 8'h01, 8'h11, 8'h12, 8'hFF};
    replay_collect(1, 1, cyc, dn, st, vs);
    ok = (got.size() == 5);
    for (int i = 0; i < 5 && ok; i++) if (got[i] !== exp_path[i]) ok = 0;
    tests++;
    if (!ok || !st || !dn) begin
      fails++; $display("FAIL replay_backpressure: got beats=%0d order_ok=%b stable=%b done=%b, expected 5 1 1 1", got.size(), ok, st, dn);
    end
    idle_cycle();
    tests++;
    if (err !== 1'b1 || top !== 8'hFF) begin
      fails++; $display("FAIL push_in_play: got err=%b top=%h, expected 1 ff", err, top);
    end
    for (int i = 0; i < 4; i++) do_op(0, 1, 8'h00);
    tests++;
    if (top !== 8'h00 || empty !== 1'b0) begin
      fails++; $display("FAIL sp_frozen: got top=%h empty=%b, expected 00 0", top, empty);
    end
  endtask

  task automatic test_rst_mid_replay();
    int cyc; bit dn, st, vs; bit seen_done;
    do_reset();
    do_op(1, 0, 8'h00); do_op(1, 0, 8'h01); do_op(1, 0, 8'h11); do_op(1, 0, 8'h12); do_op(1, 0, 8'hFF);
    run = 1'b1; @(posedge clk); #1; run = 1'b0;
    out_ready = 1'b1;
    idle_cycle(); idle_cycle();
    tests++;
    if (out_valid !== 1'b1 || out_loc !== 8'h11) begin
      fails++; $display("FAIL third_beat: got valid=%b loc=%h, expected 1 11", out_valid, out_loc);
    end
    rst = 1'b1; #1;
    tests++;
    if (out_valid !== 1'b0 || empty !== 1'b1 || run_done !== 1'b0) begin
      fails++; $display("FAIL rst_mid_replay: got valid=%b empty=%b done=%b, expected 0 1 0", out_valid, empty, run_done);
    end
    @(posedge clk); #1; rst = 1'b0;
    m_stk.delete(); m_err = 0;
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin idle_cycle(); if (run_done || out_valid) seen_done = 1; end
    out_ready = 1'b0;
    tests++;
    if (seen_done) begin fails++; $display("FAIL rst_no_done: got done/valid after reset, expected none"); end
    replay_collect(0, -1, cyc, dn, st, vs);
    idle_cycle();
    tests++;
    if (!dn || cyc != 0 || vs || out_valid !== 1'b0 || run_done !== 1'b0) begin
      fails++; $display("FAIL empty_run: got done=%b cycles=%0d valid_seen=%b, expected 1 0 0", dn, cyc, vs);
    end
  endtask

  task automatic test_clr_in_play();
    bit bad;
    do_reset();
    for (int i = 0; i < 6; i++) do_op(1, 0, 8'(i + 3));
    run = 1'b1; @(posedge clk); #1; run = 1'b0;
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    m_stk.delete(); m_err = 0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin if (out_valid || run_done) bad = 1; idle_cycle(); end
    tests++;
    if (bad || empty !== 1'b1) begin
      fails++; $display("FAIL clr_in_play: got stray_activity=%b empty=%b, expected 0 1", bad, empty);
    end
  endtask

  task automatic test_random();
    int cyc; bit dn, st, vs; bit ok;
    int k; bit p, q; logic [7:0] d;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 150; i++) begin
        k = $urandom_range(0, 9);
        p = (k < 5) || (k == 8);
        q = (k >= 5 && k <= 8);
        d = 8'($urandom);
        do_op(p, q, d);
        tests++;
        if ({top, empty, full, err} !== {m_top(), m_stk.size() == 0, m_stk.size() == DEPTH, m_err}) begin
          fails++;
          $display("FAIL rand_op r%0d i%0d: got top=%h empty=%b full=%b err=%b, expected top=%h depth=%0d err=%b",
                   r, i, top, empty, full, err, m_top(), m_stk.size(), m_err);
        end
      end
      replay_collect(2, -1, cyc, dn, st, vs);
      ok = (got.size() == m_stk.size()) && dn && st && (vs == (m_stk.size() != 0));
      for (int i = 0; i < got.size() && ok; i++) if (got[i] !== m_stk[i]) ok = 0;
      tests++;
      if (!ok) begin
        fails++; $display("FAIL rand_replay r%0d: got beats=%0d done=%b stable=%b, expected beats=%0d in push order",
                          r, got.size(), dn, st, m_stk.size());
      end
      do_clr();
    end
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; run = 1'b0;
    out_ready = 1'b0; din = 8'h00;
    #1;
    test_reset();
    test_push_pop();
    test_replace_err();
    test_full();
    test_replay();
    test_backpressure();
    test_rst_mid_replay();
    test_clr_in_play();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
